fifo_stream_reader: RTL and testbench

Read-side consumer for the team's synchronous FIFO. Pops words from the FIFO's `rd_en`/`data_out` port, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the words downstream as a valid/ready stream. It never issues a read when `fifo_empty` is set, and flags any underflow the FIFO reports as a protocol error.

---
 rtl/fifo_reader_pkg.sv | 15 +
 rtl/fifo_reader_skid.sv | 68 ++++++
 rtl/fifo_stream_reader.sv | 133 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and sizing for the FIFO stream reader.
// The reader's statistics counters are controlled by the FIFO_READER_STATS_EN macro.
package fifo_reader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int CNT_W      = 16;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry skid store that absorbs the FIFO read latency.
// slot0 is always the head; slot1 holds the second word when occ==2.
// Part of the fifo_stream_reader slice; no dependence on FIFO_READER_STATS_EN.
module fifo_reader_skid
   import fifo_reader_pkg::*;
#(
   parameter int FIFO_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic                  pop,
   input  logic [FIFO_WIDTH-1:0] din,
   output logic [FIFO_WIDTH-1:0] head,
   output logic [OCC_W-1:0]      occ
);

   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);

   logic [FIFO_WIDTH-1:0] slot0;
   logic [FIFO_WIDTH-1:0] slot1;
   logic [OCC_W-1:0]      occ_q;
   logic                  do_pop;
   logic                  do_push;

   // A pop from an empty store is ignored; a push into a full store only
   // lands when a pop frees the head in the same cycle.
   assign do_pop  = pop && (occ_q != '0);
   assign do_push = push && ((occ_q < OCC_FULL) || do_pop);

   // Storage update: clear wins over push/pop, head shifts on pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q <= '0;
         slot0 <= '0;
         slot1 <= '0;
      end else if (clr) begin
         occ_q <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (occ_q == '0) slot0 <= din;
               else             slot1 <= din;
               occ_q <= occ_q + OCC_ONE;
            end
            2'b01: begin
               slot0 <= slot1;
               occ_q <= occ_q - OCC_ONE;
            end
            2'b11: begin
               if (occ_q == OCC_ONE) begin
                  slot0 <= din;
               end else begin
                  slot0 <= slot1;
                  slot1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = slot0;
   assign occ  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops words from a synchronous FIFO and presents them
// as a valid/ready stream through a 2-entry skid store.
// Define FIFO_READER_STATS_EN to build the rd_count / stall_count counters;
// without it both ports are tied to zero.
module fifo_stream_reader
   import fifo_reader_pkg::*;
#(
   parameter int FIFO_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  flush,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  err_underflow,
   output logic [CNT_W-1:0]      rd_count,
   output logic [CNT_W-1:0]      stall_count
);

   localparam logic [OCC_W:0] PEND_LIMIT = (OCC_W+1)'(SKID_DEPTH);

   state_t                state_q;
   state_t                state_d;
   logic                  inflight;
   logic                  err_q;
   logic [OCC_W-1:0]      occ;
   logic [FIFO_WIDTH-1:0] head;
   logic                  valid;
   logic                  pop;
   logic                  push;
   logic [OCC_W:0]        pend;

   // A flush cycle delivers nothing, so valid is masked while flush is high.
   assign valid = (occ != '0) && !flush;
   assign pop   = valid && m_ready;

   // Words that will be held after this edge if nothing new is read.
   assign pend = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};

   // The returning word is dropped on underflow, on a flush pulse, and while flushing.
   assign push = inflight && !fifo_underflow && !flush && (state_q != FLUSH);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; flush takes priority over every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (flush)   state_d = FLUSH;
            else if (en) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (flush)                                  state_d = FLUSH;
            else if (!en && (occ == '0) && !inflight)   state_d = IDLE;
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read issue: only in ACTIVE, never on empty, never beyond skid capacity.
   always_comb begin
      fifo_rd_en = 1'b0;
      if ((state_q == ACTIVE) && en && !fifo_empty && (pend < PEND_LIMIT))
         fifo_rd_en = 1'b1;
   end

   // Track the outstanding read and latch any reported underflow until reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (inflight && fifo_underflow) err_q <= 1'b1;
      end
   end

   fifo_reader_skid #(
      .FIFO_WIDTH (FIFO_WIDTH)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .push  (push),
      .pop   (pop),
      .din   (fifo_data_out),
      .head  (head),
      .occ   (occ)
   );

   assign m_valid       = valid;
   assign m_data        = head;
   assign err_underflow = err_q;

`ifdef FIFO_READER_STATS_EN
   logic [CNT_W-1:0] rd_cnt_q;
   logic [CNT_W-1:0] stall_cnt_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // Delivered-word count wraps; stall count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (pop)               rd_cnt_q    <= rd_cnt_q + 1'b1;
         if (valid && !m_ready) stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   assign rd_count    = rd_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   assign rd_count    = '0;
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and randomized checks of fifo_stream_reader
// against a queue-based FIFO model and an in-order scoreboard.
module tb_fifo_stream_reader;
   import fifo_reader_pkg::*;

`ifdef FIFO_READER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        flush = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        fifo_underflow = 1'b0;
   logic        m_ready = 1'b0;
   logic [15:0] fifo_data_out = 16'h0;
   logic        fifo_rd_en;
   logic        m_valid;
   logic        err_underflow;
   logic [15:0] m_data;
   logic [15:0] rd_count;
   logic [15:0] stall_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   logic [15:0] fifo_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] model_rd = 16'h0;
   logic [15:0] model_stall = 16'h0;

   int          rd_pulses, beats, first_rd, first_v, last_v;
   bit          any_valid, err_seen, err_lost, force_uf, prev_stall;
   logic [15:0] prev_d;

   fifo_stream_reader #(.FIFO_WIDTH(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .flush          (flush),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .err_underflow  (err_underflow),
      .rd_count       (rd_count),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      rd_pulses = 0; beats = 0; first_rd = -1; first_v = -1; last_v = -1;
      any_valid = 0; err_seen = 0; err_lost = 0;
   endtask

   // One clock cycle: sample outputs mid-cycle, then act as the FIFO after the edge.
   task automatic cyc();
      logic        rd, v, r;
      logic [15:0] d;
      cyc_n++;
      #2;
      rd = fifo_rd_en; v = m_valid; r = m_ready; d = m_data;
      if (rst_n) begin
         check("read_while_empty", 32'(rd && fifo_empty), 32'd0);
         check("occ_bound", 32'(dut.occ <= 2), 32'd1);
         if (prev_stall && v) check("hold_data", 32'(d), 32'(prev_d));
         if (rd) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc_n;
         end
         if (v) begin
            any_valid = 1;
            if (first_v < 0) first_v = cyc_n;
         end
         if (err_underflow === 1'b1) err_seen = 1;
         else if (err_seen) err_lost = 1;
         if (v && r) begin
            beats++;
            last_v = cyc_n;
            model_rd = model_rd + 16'd1;
            if (exp_q.size() == 0) check("beat_spurious", 32'(d), 32'hDEAD_BEEF);
            else                   check("beat_data", 32'(d), 32'(exp_q.pop_front()));
         end
         if (v && !r && model_stall != 16'hFFFF) model_stall = model_stall + 16'd1;
         prev_stall = v && !r;
         prev_d     = d;
      end else begin
         prev_stall = 0;
      end
      @(posedge clk);
      #1;
      fifo_underflow = 1'b0;
      if (rd === 1'b1) begin
         if (force_uf) begin
            force_uf       = 0;
            fifo_underflow = 1'b1;
            fifo_data_out  = 16'hDEAD;
         end else if (fifo_q.size() != 0) begin
            fifo_data_out = fifo_q.pop_front();
            exp_q.push_back(fifo_data_out);
         end
      end
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic reset_tail();
      fifo_q.delete(); exp_q.delete();
      fifo_empty = 1'b1; fifo_underflow = 1'b0;
      model_rd = 16'h0; model_stall = 16'h0; prev_stall = 0;
      clear_obs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0; force_uf = 0;
      cyc();
      rst_n = 1'b1;
      reset_tail();
   endtask

   task automatic preload(input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(base + 16'(i));
      fifo_empty = (fifo_q.size() == 0);
   endtask

   initial begin
      int k;
      int fall;
      #1;
      do_reset();

      // Reset state.
      #1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_err", 32'(err_underflow), 32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      check("rst_stall_count", 32'(stall_count), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

      // Burst with ready held high.
      do_reset();
      preload(16'h0001, 8);
      en = 1'b1; m_ready = 1'b1;
      repeat (20) cyc();
      check("burst_latency", 32'(first_v - first_rd), 32'd2);
      check("burst_beats", 32'(beats), 32'd8);
      check("burst_back_to_back", 32'(last_v - first_v), 32'd7);
      check("burst_rd_count", 32'(rd_count), STATS ? 32'd8 : 32'd0);

      // Backpressure: ten stalled cycles, then release.
      do_reset();
      preload(16'h0001, 4);
      en = 1'b1; m_ready = 1'b0;
      k = 0;
      while (model_stall < 16'd10 && k < 40) begin cyc(); k++; end
      check("bp_stall_reached", 32'(model_stall), 32'd10);
      check("bp_rd_pulses", 32'(rd_pulses), 32'd2);
      check("bp_occ", 32'(dut.occ), 32'd2);
      check("bp_head", 32'(m_data), 32'h0001);
      m_ready = 1'b1;
      repeat (10) cyc();
      check("bp_beats", 32'(beats), 32'd4);
      check("bp_rd_pulses_total", 32'(rd_pulses), 32'd4);
      check("bp_stall_count", 32'(stall_count), STATS ? 32'd10 : 32'd0);
      check("bp_rd_count", 32'(rd_count), STATS ? 32'd4 : 32'd0);

      // Empty FIFO, then a single word arrives.
      do_reset();
      en = 1'b1; m_ready = 1'b1;
      repeat (10) cyc();
      check("empty_no_read", 32'(rd_pulses), 32'd0);
      check("empty_no_valid", 32'(any_valid), 32'd0);
      fall = cyc_n + 1;
      fifo_q.push_back(16'h00A5);
      fifo_empty = 1'b0;
      repeat (8) cyc();
      check("empty_one_read", 32'(rd_pulses), 32'd1);
      check("empty_read_cycle", 32'(first_rd), 32'(fall));
      check("empty_valid_cycle", 32'(first_v), 32'(fall + 2));
      check("empty_beats", 32'(beats), 32'd1);

      // Flush the cycle after a read is issued.
      do_reset();
      preload(16'h0011, 4);
      en = 1'b1; m_ready = 1'b1;
      k = 0;
      while (rd_pulses == 0 && k < 10) begin cyc(); k++; end
      check("flush_read_seen", 32'(rd_pulses), 32'd1);
      flush = 1'b1; en = 1'b0;
      cyc();
      flush = 1'b0;
      exp_q.delete();
      clear_obs();
      cyc(); cyc();
      check("flush_no_valid", 32'(any_valid), 32'd0);
      check("flush_state_idle", 32'(dut.state_q), 32'(IDLE));
      en = 1'b1;
      repeat (15) cyc();
      check("flush_remaining_beats", 32'(beats), 32'd3);

      // Forced underflow on the first read.
      do_reset();
      preload(16'h0031, 3);
      force_uf = 1;
      en = 1'b1; m_ready = 1'b1;
      repeat (12) cyc();
      check("uf_err", 32'(err_underflow), 32'd1);
      check("uf_err_sticky", 32'(err_lost), 32'd0);
      check("uf_beats", 32'(beats), 32'd3);
      check("uf_rd_pulses", 32'(rd_pulses), 32'd4);
      check("uf_rd_count", 32'(rd_count), STATS ? 32'd3 : 32'd0);

      // Reset in the middle of a stalled burst with both skid entries full.
      clear_obs();
      preload(16'h0041, 8);
      m_ready = 1'b0;
      k = 0;
      while (dut.occ != 2 && k < 10) begin cyc(); k++; end
      check("mid_occ2", 32'(dut.occ), 32'd2);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      #1;
      check("mid_m_valid", 32'(m_valid), 32'd0);
      check("mid_rd_count", 32'(rd_count), 32'd0);
      check("mid_stall_count", 32'(stall_count), 32'd0);
      check("mid_err", 32'(err_underflow), 32'd0);
      check("mid_rd_en", 32'(fifo_rd_en), 32'd0);
      reset_tail();

      // Randomized traffic: random enable, ready and FIFO refill.
      do_reset();
      for (int i = 0; i < 500; i++) begin
         en      = ($urandom_range(0, 9) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) begin
            fifo_q.push_back(16'($urandom()));
            fifo_empty = 1'b0;
         end
         cyc();
      end
      en = 1'b1; m_ready = 1'b1;
      k = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || m_valid) && k < 100) begin cyc(); k++; end
      check("rand_drained", 32'(exp_q.size() + fifo_q.size()), 32'd0);
      check("rand_rd_count", 32'(rd_count), STATS ? 32'(model_rd) : 32'd0);
      check("rand_stall_count", 32'(stall_count), STATS ? 32'(model_stall) : 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
